// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
// Shared sizing helpers for the first-word-fall-through FIFO and its RAM.
// There are no ports. Per-instance widths come from parameters, so each user
// derives P_DEPTH and P_CNT_W locally from these helpers.
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

  // Number of RAM entries for a given address width. This uses a shift, so
  // no clog2 is needed.
  function automatic int unsigned fifo_depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // Width of an occupancy counter that must be able to hold the full depth.
  function automatic int unsigned fifo_cnt_width(input int unsigned addr_w);
    return addr_w + 32'd1;
  endfunction

endpackage

// File: rtl/sdp_1clk_ram.sv
// ---------------------------------------------------------------------------
// sdp_1clk_ram
// Single-clock simple-dual-port RAM. It has one write port and one read port.
// The read port has a registered output with one-cycle latency.
//
// Ports:
//   clk_i      clock
//   wr_i       write enable
//   wr_addr_i  write address
//   wr_data_i  write data
//   rd_i       read enable; rd_data_o updates only when this is high
//   rd_addr_i  read address
//   rd_data_o  read data register
// ---------------------------------------------------------------------------
module sdp_1clk_ram
  import sync_fifo_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    wr_i,
  input  logic [P_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [P_DATA_WIDTH-1:0] wr_data_i,
  input  logic                    rd_i,
  input  logic [P_ADDR_WIDTH-1:0] rd_addr_i,
  output logic [P_DATA_WIDTH-1:0] rd_data_o
);

  localparam int P_DEPTH = int'(fifo_depth(P_ADDR_WIDTH));

  logic [P_DATA_WIDTH-1:0] mem_q [P_DEPTH];
  logic [P_DATA_WIDTH-1:0] rd_data_q;

  // The storage is not reset. Control logic upstream ensures that only
  // written entries are ever read. The read register holds its value when
  // rd_i is low, which keeps a stalled head word stable.
  always_ff @(posedge clk_i) begin
    if (wr_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
// First-word-fall-through FIFO built around sdp_1clk_ram. The RAM's read
// register acts as the output stage, which hides the one-cycle read latency.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   in_valid_i   write word offered
//   in_ready_o   FIFO can accept a word
//   in_data_i    write word
//   out_valid_o  out_data_o holds the head word
//   out_ready_i  consumer takes the head word
//   out_data_o   head word
//   count_o      total words held (RAM plus output stage)
//   hwm_o        peak count_o since reset (only when SYNC_FIFO_HWM_EN is defined)
//
// Optional feature macro: SYNC_FIFO_HWM_EN
// ---------------------------------------------------------------------------
module sync_fifo_fwft
  import sync_fifo_pkg::*;
#(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [P_DATA_WIDTH-1:0] in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [P_DATA_WIDTH-1:0] out_data_o,
  output logic [P_ADDR_WIDTH:0]   count_o
`ifdef SYNC_FIFO_HWM_EN
  ,
  output logic [P_ADDR_WIDTH:0]   hwm_o
`endif
);

  localparam int P_DEPTH = int'(fifo_depth(P_ADDR_WIDTH));
  localparam int P_CNT_W = int'(fifo_cnt_width(P_ADDR_WIDTH));
  localparam logic [P_CNT_W-1:0] P_FULL_CNT = P_CNT_W'(P_DEPTH);

  logic [P_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [P_CNT_W-1:0]      ram_cnt_q, ram_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic                    wr_en;
  logic                    rd_en;

  // Handshake decode. Ready depends only on registered RAM occupancy, so
  // there is no combinational path from out_ready_i to in_ready_o. A read is
  // issued whenever the RAM holds a word and the output stage is empty or
  // being drained this cycle.
  always_comb begin
    in_ready_o = (ram_cnt_q != P_FULL_CNT);
    wr_en      = in_valid_i & in_ready_o;
    rd_en      = (ram_cnt_q != '0) & (~out_valid_q | out_ready_i);
  end

  // Next-state logic. The pointers wrap naturally at the power-of-two depth.
  // The output stage fills on a read, empties on a take with no refill, and
  // otherwise holds.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + P_ADDR_WIDTH'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + P_ADDR_WIDTH'(1);
    end
    if (rd_en) begin
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
    ram_cnt_d = ram_cnt_q + P_CNT_W'(wr_en) - P_CNT_W'(rd_en);
  end

  // State registers. Reset discards every stored word by clearing the
  // occupancy and the output-stage flag. The RAM contents become unreachable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Total occupancy includes the word parked in the RAM read register.
  always_comb begin
    out_valid_o = out_valid_q;
    count_o     = ram_cnt_q + P_CNT_W'(out_valid_q);
  end

  sdp_1clk_ram #(
    .P_DATA_WIDTH (P_DATA_WIDTH),
    .P_ADDR_WIDTH (P_ADDR_WIDTH)
  ) u_ram (
    .clk_i     (clk_i),
    .wr_i      (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (in_data_i),
    .rd_i      (rd_en),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (out_data_o)
  );

`ifdef SYNC_FIFO_HWM_EN
  logic [P_CNT_W-1:0] hwm_q, hwm_d;

  // The high-water mark samples count_o each cycle. It therefore reflects
  // a new peak one edge after that peak appears.
  always_comb begin
    hwm_d = (count_o > hwm_q) ? count_o : hwm_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm_o = hwm_q;
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_fwft
// Directed self-checking bench for sync_fifo_fwft with P_ADDR_WIDTH=4.
// A queue holds every accepted word. Each consumed word is compared against
// the queue head, and count_o is compared against the queue size.
// ---------------------------------------------------------------------------
module tb_sync_fifo_fwft;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] count;
`ifdef SYNC_FIFO_HWM_EN
  logic [4:0] hwm;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] model_q[$];
  int pops     = 0;

  sync_fifo_fwft #(
    .P_DATA_WIDTH (8),
    .P_ADDR_WIDTH (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .count_o     (count)
`ifdef SYNC_FIFO_HWM_EN
    ,
    .hwm_o       (hwm)
`endif
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point. Every failure is counted and reported here.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus and update the reference queue. Handshakes
  // are evaluated before the edge, so out_data is compared with the queue
  // head at the moment the word is taken.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    logic acc;
    logic pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    acc = v & in_ready;
    pop = out_valid & r;
    if (model_q.size() == 0) begin
      checkOutput("out_valid_while_empty", {31'd0, out_valid}, 32'd0);
    end else if (pop) begin
      checkOutput("out_data", {24'd0, out_data}, {24'd0, model_q.pop_front()});
      pops++;
    end
    step();
    if (acc) model_q.push_back(d);
    checkOutput("count", {27'd0, count}, model_q.size());
  endtask

  initial begin
    int sent;
    int guard;

    // Reset and idle.
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_count", {27'd0, count}, 32'd0);
`ifdef SYNC_FIFO_HWM_EN
    checkOutput("reset_hwm", {27'd0, hwm}, 32'd0);
`endif

    // Single word 0xA5 with the consumer stalled. It appears one edge after
    // the write edge and then holds.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    checkOutput("single_valid_after_write", {31'd0, out_valid}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("single_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("single_data", {24'd0, out_data}, 32'h0000_00A5);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0);
      checkOutput("single_hold_data", {24'd0, out_data}, 32'h0000_00A5);
      checkOutput("single_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("single_drained_valid", {31'd0, out_valid}, 32'd0);

    // Fill with 17 words: 16 in the RAM plus one in the output stage.
    for (int k = 0; k < 17; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0);
      checkOutput("fill_in_ready", {31'd0, in_ready}, (k == 16) ? 32'd0 : 32'd1);
    end
    checkOutput("full_count", {27'd0, count}, 32'd17);
    // Offers made while full are ignored, even when the data changes.
    applyStimulus(1'b1, 8'hEE, 1'b0);
    applyStimulus(1'b1, 8'hEF, 1'b0);
    checkOutput("full_ignored_count", {27'd0, count}, 32'd17);
    checkOutput("full_ignored_ready", {31'd0, in_ready}, 32'd0);
`ifdef SYNC_FIFO_HWM_EN
    checkOutput("full_hwm", {27'd0, hwm}, 32'd17);
`endif
    // Drain back-to-back: one word per cycle, in order 0x00..0x10.
    for (int k = 0; k < 17; k++) begin
      checkOutput("drain_valid", {31'd0, out_valid}, 32'd1);
      if (k == 0) checkOutput("drain_first", {24'd0, out_data}, 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1);
    end
    checkOutput("drain_empty_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("drain_empty_count", {27'd0, count}, 32'd0);

    // Continuous streaming of 100 words across pointer wrap.
    sent = 0;
    pops = 0;
    guard = 0;
    while ((sent < 100 || model_q.size() != 0) && guard < 200) begin
      if (guard >= 2 && guard < 100) begin
        checkOutput("stream_valid", {31'd0, out_valid}, 32'd1);
      end
      if (sent < 100) begin
        applyStimulus(1'b1, 8'(sent), 1'b1);
        if (in_valid && model_q.size() != 0 && model_q[$] == 8'(sent)) sent++;
      end else begin
        applyStimulus(1'b0, 8'h00, 1'b1);
      end
      checkOutput("stream_count_le2", {31'd0, (count <= 5'd2)}, 32'd1);
      guard++;
    end
    checkOutput("stream_pops", pops, 32'd100);

    // Pseudo-random handshakes, then a bounded drain.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    guard = 0;
    while (model_q.size() != 0 && guard < 40) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      guard++;
    end
    checkOutput("random_drain_count", {27'd0, count}, 32'd0);
    checkOutput("random_drain_valid", {31'd0, out_valid}, 32'd0);

    // Mid-operation reset with nine words held.
    for (int k = 0; k < 9; k++) applyStimulus(1'b1, 8'h40 + 8'(k), 1'b0);
    checkOutput("pre_reset_count", {27'd0, count}, 32'd9);
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    model_q.delete();
    checkOutput("post_reset_count", {27'd0, count}, 32'd0);
    checkOutput("post_reset_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("post_reset_ready", {31'd0, in_ready}, 32'd1);
`ifdef SYNC_FIFO_HWM_EN
    checkOutput("post_reset_hwm", {27'd0, hwm}, 32'd0);
`endif
    applyStimulus(1'b1, 8'h31, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("post_reset_head", {24'd0, out_data}, 32'h0000_0031);
    pops = 0;
    guard = 0;
    while (model_q.size() != 0 && guard < 20) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      guard++;
    end
    checkOutput("post_reset_pops", pops, 32'd3);
    checkOutput("post_reset_drained", {31'd0, out_valid}, 32'd0);
`ifdef SYNC_FIFO_HWM_EN
    checkOutput("post_reset_hwm_peak", {27'd0, hwm}, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
